// File: rtl/mem_word_seq.sv
// Word load/store sequencer over a byte-wide memory port: one byte per cycle,
// little-endian, with per-byte store mask and address wrap at the top of memory.
module mem_word_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_adr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wmask,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [7:0]       writedata,
  input  logic [7:0]       memdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state;
  logic [1:0]       k;
  logic             wr_q;
  logic [WIDTH-1:0] base_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      k          <= '0;
      wr_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            base_q  <= req_adr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            k       <= '0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (!wr_q) resp_rdata[{k, 3'b000} +: 8] <= memdata;
          k <= k + 2'd1;
          // resp_valid is registered here so it is high for the whole DONE cycle
          if (k == 2'd3) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side signals decode only from registered state, never from req_*.
  always_comb begin
    req_ready = (state == IDLE);
    memwrite  = 1'b0;
    adr       = base_q;
    writedata = '0;
    if (state == XFER) begin
      memwrite  = wr_q & wmask_q[k];
      adr       = base_q + WIDTH'(k);
      writedata = wdata_q[{k, 3'b000} +: 8];
    end
  end

endmodule
